iob_eth_frame_queue: RTL and testbench

IOB_ETH_FRAME_QUEUE -- requirements
Module: iob_eth_frame_queue

---
 rtl/iob_eth_frame_queue.sv | 197 +++++++++++++++++++
 tb/tb_iob_eth_frame_queue.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iob_eth_frame_queue.sv
// iob_eth_frame_queue
//
// Stores whole Ethernet frames in a ring of fixed-size slots and replays
// them in arrival order, zero-padding short frames up to MIN_LEN bytes.
//
// Ports
//   clk, rst          : single clock, synchronous active-high reset
//   in_valid/in_ready : write-side handshake; in_data is one byte lane,
//                       in_last marks the final byte of a frame
//   in_abort          : throws away the frame currently being written
//   out_valid/out_ready : read-side handshake; out_data carries the byte,
//                       out_last marks the final (possibly pad) byte
//   out_len           : padded length of the head frame, valid with out_valid
//   nframes           : committed frames not yet fully read out
//   err_oversize      : one-cycle pulse after an oversize frame is dropped
module iob_eth_frame_queue #(
  parameter int DATA_W     = 8,
  parameter int BUF_ADDR_W = 11,
  parameter int NSLOTS_W   = 2,
  parameter int MIN_LEN    = 46
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic                in_last,
  input  logic                in_abort,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [DATA_W-1:0]   out_data,
  output logic                out_last,
  output logic [BUF_ADDR_W:0] out_len,
  output logic [NSLOTS_W:0]   nframes,
  output logic                err_oversize
);

  localparam int CW     = BUF_ADDR_W + 1;
  localparam int NW     = NSLOTS_W + 1;
  localparam int MEM_AW = NSLOTS_W + BUF_ADDR_W;
  localparam int NSLOTS = 1 << NSLOTS_W;

  localparam logic [CW-1:0] SLOT_BYTES = {1'b1, {BUF_ADDR_W{1'b0}}};
  localparam logic [NW-1:0] SLOT_COUNT = {1'b1, {NSLOTS_W{1'b0}}};
  localparam logic [CW-1:0] MIN_LEN_C  = CW'(MIN_LEN);

  logic [DATA_W-1:0] frameMem [0:(1<<MEM_AW)-1];
  logic [CW-1:0]     slotLen_q [0:NSLOTS-1];

  // Write side
  logic [NSLOTS_W-1:0] wrSlot_q, wrSlot_d;
  logic [CW-1:0]       wrCnt_q, wrCnt_d;
  logic                errOvs_q, errOvs_d;
  logic                inAccept, slotFull, memWrEn, commit;

  // Shared occupancy
  logic [NW-1:0]       nframes_q, nframes_d;

  // Read side
  logic [NSLOTS_W-1:0] rdSlot_q, rdSlot_d;
  logic [CW-1:0]       rdOff_q, rdOff_d;
  logic [CW-1:0]       rawLen_q, rawLen_d;
  logic [CW-1:0]       outLen_q, outLen_d;
  logic                outValid_q, outValid_d;
  logic                outLast_q, outLast_d;
  logic                padZero_q, padZero_d;
  logic [DATA_W-1:0]   memRd_q;
  logic                freeHead, stepByte, canStart, memRdEn;
  logic [NSLOTS_W-1:0] startSlot;
  logic [CW-1:0]       startLen, startPadLen;
  logic [MEM_AW-1:0]   rdAddr;

  assign in_ready     = !rst && (nframes_q < SLOT_COUNT);
  assign out_valid    = outValid_q;
  assign out_data     = padZero_q ? '0 : memRd_q;
  assign out_last     = outLast_q;
  assign out_len      = outLen_q;
  assign nframes      = nframes_q;
  assign err_oversize = errOvs_q;

  // Write-side next state. The byte counter saturates at the slot size, so
  // "counter already full when in_last arrives" is exactly the oversize case:
  // excess bytes are accepted but never stored, and the frame is not committed.
  always_comb begin
    inAccept = in_valid && in_ready;
    slotFull = (wrCnt_q == SLOT_BYTES);
    memWrEn  = inAccept && !in_abort && !slotFull;
    commit   = inAccept && in_last && !in_abort && !slotFull;
    errOvs_d = inAccept && in_last && !in_abort && slotFull;
    wrCnt_d  = wrCnt_q;
    wrSlot_d = wrSlot_q;
    if (in_abort || (inAccept && in_last)) begin
      wrCnt_d = '0;
    end else if (memWrEn) begin
      wrCnt_d = wrCnt_q + CW'(1);
    end
    if (commit) begin
      wrSlot_d = wrSlot_q + NSLOTS_W'(1);
    end
  end

  // Read-side next state. The output register is refilled on every handshake
  // so there are no bubbles. While a frame is on the output it is counted in
  // nframes, so another frame is ready to start only if nframes exceeds the
  // number currently on display; this lets the next frame's first byte be
  // fetched in the same cycle as the previous out_last handshake.
  always_comb begin
    freeHead    = outValid_q && outLast_q && out_ready;
    stepByte    = outValid_q && !outLast_q && out_ready;
    startSlot   = outValid_q ? rdSlot_q + NSLOTS_W'(1) : rdSlot_q;
    startLen    = slotLen_q[startSlot];
    startPadLen = (startLen < MIN_LEN_C) ? MIN_LEN_C : startLen;
    canStart    = (!outValid_q || freeHead) && (nframes_q > NW'(outValid_q));
    rdAddr      = {startSlot, {BUF_ADDR_W{1'b0}}};
    memRdEn     = 1'b0;
    rdSlot_d    = rdSlot_q;
    rdOff_d     = rdOff_q;
    rawLen_d    = rawLen_q;
    outLen_d    = outLen_q;
    outValid_d  = outValid_q;
    outLast_d   = outLast_q;
    padZero_d   = padZero_q;
    if (stepByte) begin
      rdAddr    = {rdSlot_q, rdOff_q[BUF_ADDR_W-1:0]};
      memRdEn   = 1'b1;
      outLast_d = (rdOff_q == outLen_q - CW'(1));
      padZero_d = (rdOff_q >= rawLen_q);
      rdOff_d   = rdOff_q + CW'(1);
    end else if (canStart) begin
      memRdEn    = 1'b1;
      outValid_d = 1'b1;
      outLast_d  = (startPadLen == CW'(1));
      padZero_d  = 1'b0;
      rawLen_d   = startLen;
      outLen_d   = startPadLen;
      rdOff_d    = CW'(1);
    end else if (!outValid_q || freeHead) begin
      outValid_d = 1'b0;
      outLast_d  = 1'b0;
    end
    if (freeHead) begin
      rdSlot_d = rdSlot_q + NSLOTS_W'(1);
    end
    case ({commit, freeHead})
      2'b10:   nframes_d = nframes_q + NW'(1);
      2'b01:   nframes_d = nframes_q - NW'(1);
      default: nframes_d = nframes_q;
    endcase
  end

  // Control state and per-slot lengths. padZero resets high so out_data
  // reads as zero out of reset without having to clear the data memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrSlot_q   <= '0;
      wrCnt_q    <= '0;
      errOvs_q   <= 1'b0;
      nframes_q  <= '0;
      rdSlot_q   <= '0;
      rdOff_q    <= '0;
      rawLen_q   <= '0;
      outLen_q   <= '0;
      outValid_q <= 1'b0;
      outLast_q  <= 1'b0;
      padZero_q  <= 1'b1;
      for (int i = 0; i < NSLOTS; i++) begin
        slotLen_q[i] <= '0;
      end
    end else begin
      wrSlot_q   <= wrSlot_d;
      wrCnt_q    <= wrCnt_d;
      errOvs_q   <= errOvs_d;
      nframes_q  <= nframes_d;
      rdSlot_q   <= rdSlot_d;
      rdOff_q    <= rdOff_d;
      rawLen_q   <= rawLen_d;
      outLen_q   <= outLen_d;
      outValid_q <= outValid_d;
      outLast_q  <= outLast_d;
      padZero_q  <= padZero_d;
      if (commit) begin
        slotLen_q[wrSlot_q] <= wrCnt_q + CW'(1);
      end
    end
  end

  // Frame storage: one write port, one registered read port, no reset.
  always_ff @(posedge clk) begin
    if (memWrEn) begin
      frameMem[{wrSlot_q, wrCnt_q[BUF_ADDR_W-1:0]}] <= in_data;
    end
    if (memRdEn) begin
      memRd_q <= frameMem[rdAddr];
    end
  end

endmodule

// File: tb/tb_iob_eth_frame_queue.sv
// tb_iob_eth_frame_queue
//
// Drives frames into iob_eth_frame_queue and compares every output cycle
// against a reference built from plain queues of expected bytes.
module tb_iob_eth_frame_queue;

  localparam int DATA_W     = 8;
  localparam int BUF_ADDR_W = 11;
  localparam int NSLOTS_W   = 2;
  localparam int MIN_LEN    = 46;
  localparam int SLOT_BYTES = 1 << BUF_ADDR_W;
  localparam int NSLOTS     = 1 << NSLOTS_W;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [DATA_W-1:0]   in_data;
  logic                in_last;
  logic                in_abort;
  logic                out_valid;
  logic                out_ready;
  logic [DATA_W-1:0]   out_data;
  logic                out_last;
  logic [BUF_ADDR_W:0] out_len;
  logic [NSLOTS_W:0]   nframes;
  logic                err_oversize;

  iob_eth_frame_queue #(
    .DATA_W(DATA_W), .BUF_ADDR_W(BUF_ADDR_W), .NSLOTS_W(NSLOTS_W), .MIN_LEN(MIN_LEN)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .in_abort(in_abort),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .out_len(out_len),
    .nframes(nframes), .err_oversize(err_oversize)
  );

  always #5 clk = ~clk;

  // Frame plan: length, index of the beat carrying in_abort (-1 = none),
  // data pattern base (-1 = random bytes).
  typedef struct {
    int len;
    int abortAt;
    int base;
  } plan_t;

  plan_t planQ[$];
  int    beatIdx;
  int    wrBuf[$];
  int    expData[$];
  int    expLast[$];
  int    expLen[$];
  int    modelN;
  bit    errPending;
  int    latTimer;
  bit    expectValid;
  int    errSeen;
  int    pValid;
  int    pReady;
  int    total;
  int    bad;

  // Single comparison point: counts and reports.
  task automatic checkOutput(input string tag, input int obs, input int expVal);
    total++;
    if (obs != expVal) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, obs, expVal);
    end
  endtask

  // Drive one cycle's worth of inputs from the head of the frame plan.
  task automatic applyStimulus();
    plan_t p;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_abort  = 1'b0;
    in_data   = 8'($urandom);
    if (planQ.size() > 0 && $urandom_range(99) < pValid) begin
      p        = planQ[0];
      in_valid = 1'b1;
      in_data  = (p.base < 0) ? 8'($urandom) : 8'(p.base + beatIdx);
      in_last  = (beatIdx == p.len - 1);
      in_abort = (beatIdx == p.abortAt);
    end
    out_ready = ($urandom_range(99) < pReady);
  endtask

  task automatic resetModel();
    planQ.delete();
    wrBuf.delete();
    expData.delete();
    expLast.delete();
    expLen.delete();
    beatIdx     = 0;
    modelN      = 0;
    errPending  = 1'b0;
    latTimer    = 0;
    expectValid = 1'b0;
  endtask

  // One clock: drive, compare at the falling edge, update the reference.
  task automatic cycle();
    int nPrev;
    int len;
    int padLen;
    applyStimulus();
    @(negedge clk);
    nPrev = modelN;
    if (latTimer == 1) begin
      checkOutput("lat_cycle1_valid", int'(out_valid), 0);
      latTimer = 2;
    end else if (latTimer == 2) begin
      checkOutput("lat_cycle2_valid", int'(out_valid), 1);
      latTimer = 0;
    end
    if (expectValid) checkOutput("no_bubble_valid", int'(out_valid), 1);
    expectValid = 1'b0;
    checkOutput("nframes", int'(nframes), modelN);
    checkOutput("in_ready", int'(in_ready), int'(modelN < NSLOTS));
    checkOutput("err_oversize", int'(err_oversize), int'(errPending));
    errSeen += int'(err_oversize);
    errPending = 1'b0;

    // Read side: the head of the expected stream must be on the output.
    if (out_valid) begin
      if (expData.size() == 0) begin
        checkOutput("spurious_valid", int'(out_valid), 0);
      end else begin
        checkOutput("out_data", int'(out_data), expData[0]);
        checkOutput("out_last", int'(out_last), expLast[0]);
        checkOutput("out_len", int'(out_len), expLen[0]);
        if (out_ready) begin
          if (expLast[0] != 0) modelN--;
          void'(expData.pop_front());
          void'(expLast.pop_front());
          void'(expLen.pop_front());
          expectValid = (expData.size() > 0);
        end
      end
    end

    // Write side: abort wins, otherwise accepted bytes collect until in_last.
    if (in_abort) begin
      wrBuf.delete();
      void'(planQ.pop_front());
      beatIdx = 0;
    end else if (in_valid && in_ready) begin
      wrBuf.push_back(int'(in_data));
      beatIdx++;
      if (in_last) begin
        len = wrBuf.size();
        if (len > SLOT_BYTES) begin
          errPending = 1'b1;
        end else begin
          if (nPrev == 0) latTimer = 1;
          padLen = (len < MIN_LEN) ? MIN_LEN : len;
          for (int i = 0; i < padLen; i++) begin
            expData.push_back((i < len) ? wrBuf[i] : 0);
            expLast.push_back(int'(i == padLen - 1));
            expLen.push_back(padLen);
          end
          modelN++;
        end
        wrBuf.delete();
        void'(planQ.pop_front());
        beatIdx = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic runUntilIdle(input int budget);
    int n = 0;
    while (planQ.size() > 0 && n < budget) begin
      cycle();
      n++;
    end
    if (planQ.size() > 0) checkOutput("input_timeout", planQ.size(), 0);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((expData.size() > 0 || modelN > 0) && n < budget) begin
      cycle();
      n++;
    end
    if (expData.size() > 0) checkOutput("drain_timeout", expData.size(), 0);
    checkOutput("idle_nframes", int'(nframes), 0);
  endtask

  // Main sequence: reset, directed frames, randomized traffic, mid-read reset.
  initial begin
    int n;
    int len;
    total     = 0;
    bad       = 0;
    errSeen   = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    in_abort  = 1'b0;
    out_ready = 1'b0;
    pValid    = 100;
    pReady    = 100;
    resetModel();

    @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", int'(in_ready), 0);
    checkOutput("rst_nframes", int'(nframes), 0);
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out_last", int'(out_last), 0);
    checkOutput("rst_out_data", int'(out_data), 0);
    checkOutput("rst_out_len", int'(out_len), 0);
    checkOutput("rst_err", int'(err_oversize), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // 60-byte frame 0x00..0x3B, then a 10-byte frame that needs padding.
    planQ.push_back('{60, -1, 0});
    runUntilIdle(200);
    drain(200);
    planQ.push_back('{10, -1, 8'h80});
    runUntilIdle(100);
    drain(200);

    // Fill all slots with the reader stalled, then free one and wrap.
    pReady = 0;
    for (int i = 0; i < NSLOTS; i++) planQ.push_back('{12, -1, 16 * i});
    runUntilIdle(400);
    repeat (3) cycle();
    checkOutput("full_nframes", int'(nframes), NSLOTS);
    checkOutput("full_in_ready", int'(in_ready), 0);
    planQ.push_back('{12, -1, 8'hC0});
    repeat (5) cycle();
    pReady = 100;
    n = 0;
    while (modelN == NSLOTS && n < 200) begin
      cycle();
      n++;
    end
    checkOutput("freed_in_ready", int'(in_ready), 1);
    runUntilIdle(200);
    drain(1000);

    // Oversize frame followed by a normal one.
    errSeen = 0;
    planQ.push_back('{SLOT_BYTES + 1, -1, -1});
    planQ.push_back('{30, -1, -1});
    runUntilIdle(SLOT_BYTES + 200);
    drain(500);
    checkOutput("oversize_pulses", errSeen, 1);

    // Abort after 20 bytes, abort on an in_last beat, then a 50-byte frame.
    planQ.push_back('{60, 20, -1});
    planQ.push_back('{8, 7, -1});
    planQ.push_back('{50, -1, -1});
    runUntilIdle(300);
    drain(300);

    // Second frame's commit lands on the first frame's out_last handshake.
    planQ.push_back('{10, -1, -1});
    planQ.push_back('{47, -1, -1});
    runUntilIdle(300);
    drain(300);

    // Randomized traffic with random valid/ready and occasional aborts.
    pValid = 70;
    pReady = 60;
    for (int f = 0; f < 40; f++) begin
      len = $urandom_range(1, 90);
      planQ.push_back('{len, ($urandom_range(7) == 0) ? int'($urandom_range(0, len - 1)) : -1, -1});
    end
    runUntilIdle(20000);
    pReady = 100;
    drain(2000);

    // Reset in the middle of reading with two frames queued.
    pValid = 100;
    pReady = 0;
    planQ.push_back('{20, -1, -1});
    planQ.push_back('{20, -1, -1});
    runUntilIdle(200);
    repeat (3) cycle();
    pReady = 100;
    repeat (5) cycle();
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_abort  = 1'b0;
    out_ready = 1'b0;
    @(negedge clk);
    checkOutput("midrst_in_ready_low", int'(in_ready), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("postrst_nframes", int'(nframes), 0);
    checkOutput("postrst_out_valid", int'(out_valid), 0);
    checkOutput("postrst_in_ready", int'(in_ready), 1);
    checkOutput("postrst_err", int'(err_oversize), 0);
    @(posedge clk);
    #1;
    resetModel();
    planQ.push_back('{5, -1, 8'h40});
    runUntilIdle(100);
    drain(200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
